// File: rtl/buttons_wb_if.sv
// Wishbone slave bus bundle between the GPMC bridge and the button block.
// Master drives address/data/strobes; slave returns a registered ack and read data.
interface buttons_wb_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] wbs_address;
  logic [DATA_WIDTH-1:0] wbs_writedata;
  logic [DATA_WIDTH-1:0] wbs_readdata;
  logic                  wbs_write;
  logic                  wbs_cycle;
  logic                  wbs_strobe;
  logic                  wbs_ack;

  modport master (
    output wbs_address, wbs_writedata, wbs_write, wbs_cycle, wbs_strobe,
    input  wbs_readdata, wbs_ack
  );

  modport slave (
    input  wbs_address, wbs_writedata, wbs_write, wbs_cycle, wbs_strobe,
    output wbs_readdata, wbs_ack
  );
endinterface

// File: rtl/buttons_wb.sv
// Button sampler: 2-flop sync, per-button debounce, W1C press events, irq and a 4-register Wishbone map.
// Ack and read data one edge after a request; a held strobe is acked every other cycle.
module buttons_wb #(
  parameter int ADDR_WIDTH      = 2,
  parameter int DATA_WIDTH      = 16,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic             o_irq,
  buttons_wb_if.slave      wb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]      r_sync1;
  logic [N_BTN-1:0]      r_sync2;
  logic [N_BTN-1:0]      r_stable;
  logic [N_BTN-1:0]      r_event;
  logic [N_BTN-1:0]      r_irq_en;
  logic [CW-1:0]         r_cnt [N_BTN];
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_irq;

  logic                  w_req;
  logic                  w_wr_event;
  logic                  w_wr_en;
  logic [N_BTN-1:0]      w_flip;
  logic [N_BTN-1:0]      w_rise;
  logic [N_BTN-1:0]      w_clr;
  logic [N_BTN-1:0]      w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                  w_unused;

  assign w_req      = wb.wbs_cycle & wb.wbs_strobe & ~r_ack;
  assign w_wdata    = wb.wbs_writedata[N_BTN-1:0];
  assign w_wr_event = w_req & wb.wbs_write & (wb.wbs_address[1:0] == 2'd1);
  assign w_wr_en    = w_req & wb.wbs_write & (wb.wbs_address[1:0] == 2'd2);
  assign w_clr      = w_wr_event ? w_wdata : '0;
  assign w_unused   = &{1'b0, wb.wbs_writedata, wb.wbs_address};

  // A button flips when its counter is at the terminal count and sync still disagrees.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_flip[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == TERM);
    end
  end
  assign w_rise = w_flip & r_sync2;

  always_comb begin
    w_rd_mux = '0;
    case (wb.wbs_address[1:0])
      2'd0:    w_rd_mux[N_BTN-1:0] = r_stable;
      2'd1:    w_rd_mux[N_BTN-1:0] = r_event;
      2'd2:    w_rd_mux[N_BTN-1:0] = r_irq_en;
      default: w_rd_mux[N_BTN-1:0] = r_sync2;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= i_btn;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_flip;
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_stable[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Hardware set is OR-ed after the clear so a same-edge press survives a W1C.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_event  <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_event <= (r_event & ~w_clr) | w_rise;
      if (w_wr_en) begin
        r_irq_en <= w_wdata;
      end
      r_irq <= |(r_event & r_irq_en);
      r_ack <= w_req;
      if (w_req && !wb.wbs_write) begin
        r_rdata <= w_rd_mux;
      end else begin
        r_rdata <= '0;
      end
    end
  end

  assign wb.wbs_ack      = r_ack;
  assign wb.wbs_readdata = r_rdata;
  assign o_irq           = r_irq;
endmodule

// File: tb/tb_buttons_wb.sv
// Randomized and directed bench for buttons_wb with a queue-based scoreboard
// fed by a window-based reference model of the debouncer and register map.
module tb_buttons_wb;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int N  = 2;
  localparam int D  = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn;
  logic         irq;

  buttons_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  buttons_wb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_BTN(N), .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_btn(btn), .o_irq(irq), .wb(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [N-1:0]  m_s1, m_s2, m_stable, m_event, m_en;
  logic          m_ack, m_irq;
  logic [N-1:0]  hist [$];
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] rd_model(input logic [1:0] a);
    logic [DW-1:0] v;
    v = '0;
    case (a)
      2'd0:    v[N-1:0] = m_stable;
      2'd1:    v[N-1:0] = m_event;
      2'd2:    v[N-1:0] = m_en;
      default: v[N-1:0] = m_s2;
    endcase
    return v;
  endfunction

  // A button is accepted once the last D synchronized samples all disagree with its stable value.
  always @(posedge clk) begin : model
    logic [N-1:0] flip, rise, clr;
    logic         req;
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_event <= '0; m_en <= '0;
      m_ack <= 1'b0; m_irq <= 1'b0;
      hist.delete();
    end else begin
      req = bus.wbs_cycle & bus.wbs_strobe & ~m_ack;
      if (req) exp_q.push_back(bus.wbs_write ? '0 : rd_model(bus.wbs_address));
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      flip = '0;
      for (int i = 0; i < N; i++) begin
        if (hist.size() == D) begin
          flip[i] = 1'b1;
          foreach (hist[k]) if (hist[k][i] == m_stable[i]) flip[i] = 1'b0;
        end
      end
      rise = flip & ~m_stable;
      clr  = (req && bus.wbs_write && bus.wbs_address == 2'd1) ? bus.wbs_writedata[N-1:0] : '0;
      m_event  <= (m_event & ~clr) | rise;
      if (req && bus.wbs_write && bus.wbs_address == 2'd2) m_en <= bus.wbs_writedata[N-1:0];
      m_stable <= m_stable ^ flip;
      m_irq    <= |(m_event & m_en);
      m_ack    <= req;
      m_s2     <= m_s1;
      m_s1     <= btn;
    end
  end

  // Monitor: compares every cycle, pops an expected read word on each ack.
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    n_vec++;
    if (bus.wbs_ack !== m_ack) begin
      n_err++; $display("FAIL ack: got %b want %b at %0t", bus.wbs_ack, m_ack, $time);
    end
    n_vec++;
    if (irq !== m_irq) begin
      n_err++; $display("FAIL irq: got %b want %b at %0t", irq, m_irq, $time);
    end
    n_vec++;
    if (bus.wbs_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL ack_unexpected: got ack with no pending request at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.wbs_readdata !== e) begin
          n_err++; $display("FAIL rdata: got %h want %h at %0t", bus.wbs_readdata, e, $time);
        end
      end
    end else if (bus.wbs_readdata !== '0) begin
      n_err++; $display("FAIL rdata_idle: got %h want 0000 at %0t", bus.wbs_readdata, $time);
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++; $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at a negedge; request is sampled on the following edge.
  task automatic bus_op(input logic wr, input logic [1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd);
    if (bus.wbs_ack) idle(1);
    bus.wbs_cycle = 1'b1; bus.wbs_strobe = 1'b1; bus.wbs_write = wr;
    bus.wbs_address = a; bus.wbs_writedata = d;
    @(posedge clk);
    @(negedge clk);
    rd = bus.wbs_readdata;
    bus.wbs_cycle = 1'b0; bus.wbs_strobe = 1'b0; bus.wbs_write = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [DW-1:0] rd;
    rst_n = 1'b0; btn = '0;
    bus.wbs_cycle = 1'b0; bus.wbs_strobe = 1'b0; bus.wbs_write = 1'b0;
    bus.wbs_address = '0; bus.wbs_writedata = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_irq", {15'd0, irq}, 16'h0);
      chk("rst_ack", {15'd0, bus.wbs_ack}, 16'h0);
    end
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_op(1'b0, 2'(a), '0, rd);
      chk("reset_read", rd, 16'h0000);
    end

    // Clean press on btn[0]
    idle(2);
    btn[0] = 1'b1;
    idle(1);
    bus_op(1'b0, 2'd3, '0, rd); chk("raw_edge1", rd, 16'h0000);
    bus_op(1'b0, 2'd0, '0, rd); chk("state_edge3", rd, 16'h0000);
    idle(2);
    bus_op(1'b0, 2'd0, '0, rd); chk("state_edge6", rd, 16'h0001);
    bus_op(1'b0, 2'd1, '0, rd); chk("event_press", rd, 16'h0001);
    bus_op(1'b0, 2'd3, '0, rd); chk("raw_press", rd, 16'h0001);

    btn[0] = 1'b0;
    idle(8);
    bus_op(1'b1, 2'd1, 16'h0003, rd);
    bus_op(1'b1, 2'd2, 16'h0003, rd);
    bus_op(1'b0, 2'd2, '0, rd); chk("irq_en_rb", rd, 16'h0003);

    // Bounce rejection on btn[1]
    for (int i = 0; i < 10; i++) begin
      btn[1] = (i % 2 == 0);
      repeat (2) begin idle(1); chk("bounce_irq", {15'd0, irq}, 16'h0); end
    end
    btn[1] = 1'b0;
    repeat (8) begin idle(1); chk("bounce_irq", {15'd0, irq}, 16'h0); end
    bus_op(1'b0, 2'd0, '0, rd); chk("bounce_state", rd, 16'h0000);
    bus_op(1'b0, 2'd1, '0, rd); chk("bounce_event", rd, 16'h0000);
    idle(1);

    // Interrupt and W1C
    btn[1] = 1'b1;
    idle(6); chk("irq_edge5", {15'd0, irq}, 16'h0);
    idle(1); chk("irq_edge6", {15'd0, irq}, 16'h1);
    bus_op(1'b1, 2'd1, 16'h0001, rd);
    idle(1); chk("irq_wrong_bit", {15'd0, irq}, 16'h1);
    bus_op(1'b1, 2'd1, 16'h0002, rd);
    chk("irq_ack_edge", {15'd0, irq}, 16'h1);
    idle(1); chk("irq_cleared", {15'd0, irq}, 16'h0);
    bus_op(1'b0, 2'd1, '0, rd); chk("event_cleared", rd, 16'h0000);

    // Set/clear collision on btn[0]
    btn[0] = 1'b1; idle(8);
    btn[0] = 1'b0; idle(8);
    btn[0] = 1'b1;
    idle(5);
    bus_op(1'b1, 2'd1, 16'h0001, rd);
    bus_op(1'b0, 2'd1, '0, rd); chk("collision", rd, 16'h0001);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) btn = N'($urandom);
      if ($urandom_range(0, 1) == 1)
        bus_op(1'($urandom), 2'($urandom), 16'($urandom), rd);
      else
        idle($urandom_range(1, 8));
    end
    idle(2);

    // Held strobe on IRQ_EN read
    bus.wbs_cycle = 1'b1; bus.wbs_strobe = 1'b1; bus.wbs_write = 1'b0; bus.wbs_address = 2'd2;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("held_ack", {15'd0, bus.wbs_ack}, (i % 2 == 0) ? 16'h1 : 16'h0);
    end
    bus.wbs_cycle = 1'b0;
    idle(1);
    repeat (3) begin idle(1); chk("no_cyc_ack", {15'd0, bus.wbs_ack}, 16'h0); end
    bus.wbs_strobe = 1'b0;

    // Reset during an ack cycle
    bus.wbs_cycle = 1'b1; bus.wbs_strobe = 1'b1; bus.wbs_address = 2'd0;
    idle(1);
    chk("pre_rst_ack", {15'd0, bus.wbs_ack}, 16'h1);
    rst_n = 1'b0;
    bus.wbs_cycle = 1'b0; bus.wbs_strobe = 1'b0;
    idle(1);
    chk("rst_drop_ack", {15'd0, bus.wbs_ack}, 16'h0);
    chk("rst_rdata", bus.wbs_readdata, 16'h0);
    rst_n = 1'b1;
    btn = '0;
    bus_op(1'b0, 2'd2, '0, rd); chk("post_rst_en", rd, 16'h0000);
    idle(2);

    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/buttons_wb.md
# buttons_wb

Wishbone slave that samples the BeagleWire push-buttons, debounces them, and exposes debounced state, latched press events and an interrupt through a four-register map. It is the input-side counterpart of the LED slave: it sits behind `gpmc_to_wishbone` on the same Wishbone bus, so the BeagleBone reads button state over GPMC.

## Interface
- `ADDR_WIDTH`, default 2: Wishbone address width; only `wbs_address[1:0]` is decoded.
- `DATA_WIDTH`, default 16: Wishbone data width.
- `N_BTN`, default 2: number of buttons; must be ≤ `DATA_WIDTH`.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a change; minimum 2.
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-low reset.
- `btn`  in  `N_BTN`: raw button inputs, asynchronous to `clk`, active-high.
- `irq`  out  1: registered interrupt, level-sensitive.
- `wbs_address`  in  `ADDR_WIDTH`: register select.
- `wbs_writedata`  in  `DATA_WIDTH`: write data.
- `wbs_readdata`  out  `DATA_WIDTH`: read data, registered.
- `wbs_write`  in  1: 1 = write, 0 = read.
- `wbs_cycle`  in  1: bus cycle in progress.
- `wbs_strobe`  in  1: valid transfer.
- `wbs_ack`  out  1: single-cycle acknowledge.

## Operation
- **Synchronizer:** per-bit 2-flop synchronizer, `btn` → `sync`.
- **Debounce:**
  - Each button has a counter of width $clog2(`DEBOUNCE_CYCLES`+1) and a `stable` bit.
  - If `sync` == `stable`, the counter clears.
  - Otherwise the counter increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `stable` ← `sync` and the counter clears.
  - Any bounce back to the `stable` value clears the counter.
- **Events:** a `stable` 0→1 transition sets `event[i]`. Release (1→0) sets nothing.
- **Register map** (`wbs_address[1:0]`):
  - 0 `STATE`: RO, `stable` bits.
  - 1 `EVENT`: writing 1 to a bit clears it (W1C).
  - 2 `IRQ_EN`: RW, `N_BTN` bits.
  - 3 `RAW`: RO, `sync` bits.
  - Bits ≥ `N_BTN` read 0. Writes to RO registers are ignored.
- **IRQ:** `irq` ← |(`event` & `irq_en`), registered.
- **Handshake:**
  - A request is `wbs_cycle` & `wbs_strobe` & !`wbs_ack`.
  - On a request edge, `wbs_ack` ← 1. Reads load `wbs_readdata`; writes update the register.
  - The next edge forces `wbs_ack` ← 0, so a held strobe is acked every other cycle.
  - `wbs_readdata` holds its value while `wbs_ack` is high and is 0 otherwise.
  - A strobe without `wbs_cycle` is ignored.
- **Same-edge set and clear:** the hardware set of an `event` bit wins over a W1C clear of that bit.
- **Reset:** applies when `reset`=0 on a `clk` edge.
  - All state clears: synchronizers, counters, `stable`, `event`, `irq_en`.
  - Outputs clear: `wbs_ack`=0, `wbs_readdata`=0, `irq`=0.
  - Reset mid-transaction drops the ack. The master must reissue.

## Timing
- Define edge 0 as the first `clk` edge sampling a new `btn` level, held constant from then on.
  - `sync` reflects the new level after edge 1.
  - `stable` and `event` update at edge 1+`DEBOUNCE_CYCLES`.
  - `irq` rises one edge after `event` sets, if enabled.
- Bus reads:
  - `wbs_ack` and `wbs_readdata` are valid one edge after the request is sampled.
  - Read data reflects register contents before that edge.
- Bus writes:
  - Take effect at the ack edge.
  - `irq` reflects a W1C clear or an `IRQ_EN` change one edge later.
- Throughput is at most one transfer per 2 cycles.
- Counter overflow is impossible: the counter saturates by clearing at the terminal count.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4 and `N_BTN`=2.
- **Reset values:** hold `reset`=0 for 3 cycles, release, read addresses 0–3 → all read 0x0000. `irq`=0 and `wbs_ack`=0 throughout reset.
- **Clean press:** raise `btn[0]` at edge 0 and hold → `STATE` reads 0x0001 and `EVENT` bit 0 is set, both from edge 5. `RAW` reads 0x0001 from edge 2.
- **Bounce rejection:** toggle `btn[1]` 1/0 every 2 cycles for 20 cycles, then hold it at 0 → `STATE`=0, `EVENT`=0, `irq` never asserts.
- **Interrupt and W1C:**
  - Write `IRQ_EN`=0x0003, then press `btn[1]` → `irq`=1 one cycle after the event.
  - Write 0x0002 to `EVENT` → `EVENT` reads 0 and `irq`=0 one cycle after the ack.
  - Writing 0x0001 instead leaves `irq` high.
- **Set/clear collision:** time a W1C of bit 0 to land on the same edge as a new `btn[0]` press event → `EVENT` bit 0 remains 1.
- **Handshake:**
  - Hold `wbs_cycle`=`wbs_strobe`=1 for 6 cycles on a read of addr 2 → `wbs_ack` pulses 1,0,1,0,1,0.
  - Assert `wbs_strobe` with `wbs_cycle`=0 → no ack.
  - Pull `reset` low during an ack cycle → `wbs_ack`=0 on the next edge.
